// File: rtl/myy_oper_arbiter.sv
// myy_oper_arbiter: round-robin arbiter sharing one single-operation
// microprogram control unit between N_REQ requesters.
// Optional watchdog abort is built only when MYY_ARB_TIMEOUT_EN is defined;
// without it BUSY waits for sko indefinitely and err/err_flag are tied low.
module myy_oper_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int SELW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             set,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SELW-1:0]  sel,
  output logic             sno,
  input  logic             sko,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             err,
  output logic             err_flag
);

  // Reject configurations outside the supported range at elaboration.
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("myy_oper_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 1024) begin : g_bad_timeout
    $error("myy_oper_arbiter: TIMEOUT must be in 2..1024");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             sno_q, sno_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [SELW-1:0]  win_idx;
  logic [SELW-1:0]  cand;

`ifdef MYY_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT);
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
`endif

  // Round-robin pick: first set req bit scanning from ptr upward, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = SELW'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    sno_d   = 1'b0;
    done_d  = '0;
`ifdef MYY_ARB_TIMEOUT_EN
    cnt_d      = '0;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_START;
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_d   = win_idx;
          sno_d   = 1'b1;
        end
      end
      S_START: begin
        // sko is deliberately not looked at here: the unit has only just started.
        state_d = S_BUSY;
      end
      S_BUSY: begin
`ifdef MYY_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNTW'(1);
`endif
        if (sko) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end
`ifdef MYY_ARB_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          // Watchdog abort: enter DONE without a done pulse.
          state_d    = S_DONE;
          err_d      = 1'b1;
          err_flag_d = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = (sel_q == SELW'(N_REQ - 1)) ? '0 : sel_q + SELW'(1);
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; everything clears while set is low.
  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      sno_q   <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
`ifdef MYY_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      sno_q   <= sno_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MYY_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign sno  = sno_q;
  assign done = done_q;
  assign busy = busy_q;

`ifdef MYY_ARB_TIMEOUT_EN
  assign err      = err_q;
  assign err_flag = err_flag_q;
`else
  assign err      = 1'b0;
  assign err_flag = 1'b0;
`endif

endmodule
